// File: rtl/bcd_contador_if.sv
// Shared BCD digit type and the bus bundle between the button/tick side
// and the counter. The counter takes the slave side; the stimulus or parent
// block takes the master side.
package bcd_pkg;
  typedef struct packed {
    logic [3:0] digito;
    logic       dp;
  } BCDnumber_t;
endpackage

interface bcd_contador_if #(
  parameter int NRO_DIGITOS = 4
);
  import bcd_pkg::*;

  logic                         tick;
  logic                         btn_up;
  logic                         btn_down;
  logic                         clear;
  BCDnumber_t [NRO_DIGITOS-1:0] num;
  logic                         wrap;

  modport master (output tick, btn_up, btn_down, clear, input num, wrap);
  modport slave  (input tick, btn_up, btn_down, clear, output num, wrap);
endinterface

// File: rtl/bcd_contador.sv
// Up/down BCD counter with push-button auto-repeat paced by the shared tick
// strobe, a synchronous clear and a one-cycle roll-over strobe.
module bcd_contador
  import bcd_pkg::*;
#(
  parameter int NRO_DIGITOS  = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100,
  parameter int DP_POS       = NRO_DIGITOS
) (
  input logic           clk,
  input logic           rst,
  bcd_contador_if.slave bus
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DELAY_C = cnt_t'(REPEAT_DELAY);
  localparam cnt_t RATE_C  = cnt_t'(REPEAT_RATE);
  localparam cnt_t SAT_C   = cnt_t'(CNT_MAX);

  typedef enum logic [1:0] {IDLE, WAIT, REPEAT, LOCK} state_t;

  state_t                     state_q, state_d;
  cnt_t                       cnt_q, cnt_d;
  logic                       dir_q, dir_d;   // 1 = counting up
  logic                       up_q, up_d;
  logic                       dn_q, dn_d;
  logic [NRO_DIGITOS-1:0][3:0] digits_q, digits_d;
  logic                       wrap_q, wrap_d;

  logic [NRO_DIGITOS-1:0][3:0] inc_digits, dec_digits;
  logic                       carry_up, borrow_dn;

  // Ripple increment and decrement candidates of the held value.
  always_comb begin
    carry_up  = 1'b1;
    borrow_dn = 1'b1;
    for (int i = 0; i < NRO_DIGITOS; i++) begin
      if (!carry_up) begin
        inc_digits[i] = digits_q[i];
      end else if (digits_q[i] == 4'd9) begin
        inc_digits[i] = 4'd0;
      end else begin
        inc_digits[i] = digits_q[i] + 4'd1;
        carry_up      = 1'b0;
      end

      if (!borrow_dn) begin
        dec_digits[i] = digits_q[i];
      end else if (digits_q[i] == 4'd0) begin
        dec_digits[i] = 4'd9;
      end else begin
        dec_digits[i] = digits_q[i] - 4'd1;
        borrow_dn     = 1'b0;
      end
    end
  end

  // Button FSM, repeat timing, value update and clear override.
  always_comb begin
    logic do_step, step_up, rise_up, rise_dn, act_btn, opp_btn;
    cnt_t cnt_inc;

    // NOTE: every output gets a default first so no path infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    up_d     = bus.btn_up;
    dn_d     = bus.btn_down;
    digits_d = digits_q;
    wrap_d   = 1'b0;
    do_step  = 1'b0;
    step_up  = dir_q;

    rise_up = bus.btn_up & ~up_q;
    rise_dn = bus.btn_down & ~dn_q;
    act_btn = dir_q ? bus.btn_up : bus.btn_down;
    opp_btn = dir_q ? bus.btn_down : bus.btn_up;
    cnt_inc = (cnt_q == SAT_C) ? cnt_q : cnt_q + cnt_t'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.btn_up && bus.btn_down) begin
          state_d = LOCK;
        end else if (rise_up && !bus.btn_down) begin
          do_step = 1'b1;
          step_up = 1'b1;
          dir_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (rise_dn && !bus.btn_up) begin
          do_step = 1'b1;
          step_up = 1'b0;
          dir_d   = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT, REPEAT: begin
        // A pressed opposite button wins over a coinciding tick.
        if (opp_btn) begin
          state_d = LOCK;
        end else if (!act_btn) begin
          state_d = IDLE;
        end else if (bus.tick) begin
          if (cnt_inc >= ((state_q == WAIT) ? DELAY_C : RATE_C)) begin
            do_step = 1'b1;
            cnt_d   = '0;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      LOCK: begin
        if (!bus.btn_up && !bus.btn_down) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (do_step) begin
      digits_d = step_up ? inc_digits : dec_digits;
      wrap_d   = step_up ? carry_up : borrow_dn;
    end

    if (bus.clear) begin
      digits_d = '0;
      wrap_d   = 1'b0;
      cnt_d    = '0;
      state_d  = (bus.btn_up || bus.btn_down) ? LOCK : IDLE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      digits_q <= digits_d;
      wrap_q   <= wrap_d;
    end
  end

  // Output packing; dp bits are fixed by DP_POS.
  always_comb begin
    for (int i = 0; i < NRO_DIGITOS; i++) begin
      bus.num[i].digito = digits_q[i];
      bus.num[i].dp     = (i == DP_POS);
    end
    bus.wrap = wrap_q;
  end

endmodule

// File: tb/tb_bcd_contador.sv
// Self-checking bench for bcd_contador: a value-level model predicts num and
// wrap each cycle, plus literal checkpoints along directed button sequences.
module tb_bcd_contador;
  localparam int NDIG   = 4;
  localparam int DELAY  = 3;
  localparam int RATE   = 2;
  localparam int DPP    = 1;
  localparam int MODULO = 10000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bcd_contador_if #(.NRO_DIGITOS(NDIG)) bus ();

  bcd_contador #(
    .NRO_DIGITOS (NDIG),
    .REPEAT_DELAY(DELAY),
    .REPEAT_RATE (RATE),
    .DP_POS      (DPP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [5*NDIG-1:0] to_num(input int v);
    logic [5*NDIG-1:0] r;
    int p;
    p = 1;
    for (int i = 0; i < NDIG; i++) begin
      r[i*5+1 +: 4] = 4'((v / p) % 10);
      r[i*5]        = (i == DPP);
      p             = p * 10;
    end
    return r;
  endfunction

  // Model: value as an integer, repeat timing as ticks counted since press.
  int val = 0;
  bit mwrap = 0;
  bit prev_up = 0, prev_dn = 0;
  bit active = 0, locked = 0, mdir = 0;
  int nticks = 0;

  task automatic model_step(input bit up);
    if (up) begin
      if (val == MODULO - 1) begin val = 0; mwrap = 1; end
      else val = val + 1;
    end else begin
      if (val == 0) begin val = MODULO - 1; mwrap = 1; end
      else val = val - 1;
    end
  endtask

  always @(posedge clk) begin
    bit up, dn, act, opp;
    up = bus.btn_up;
    dn = bus.btn_down;
    if (rst) begin
      val = 0; mwrap = 0; active = 0; locked = 0; prev_up = 0; prev_dn = 0;
    end else begin
      mwrap = 0;
      if (bus.clear) begin
        val = 0; active = 0; locked = up | dn;
      end else if (locked) begin
        if (!up && !dn) locked = 0;
      end else if (active) begin
        act = mdir ? up : dn;
        opp = mdir ? dn : up;
        if (opp) begin
          active = 0; locked = 1;
        end else if (!act) begin
          active = 0;
        end else if (bus.tick) begin
          nticks++;
          if (nticks == DELAY || (nticks > DELAY && (nticks - DELAY) % RATE == 0))
            model_step(mdir);
        end
      end else begin
        if (up && dn) locked = 1;
        else if (up && !prev_up) begin
          model_step(1); active = 1; mdir = 1; nticks = 0;
        end else if (dn && !prev_dn) begin
          model_step(0); active = 1; mdir = 0; nticks = 0;
        end
      end
      prev_up = up;
      prev_dn = dn;
    end
  end

  // Per-cycle comparison against the model, plus a wrap pulse counter.
  bit cmp_en = 0;
  int wrap_seen = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("num_vs_model", 32'(bus.num), 32'(to_num(val)));
      check("wrap_vs_model", 32'(bus.wrap), 32'(mwrap));
      if (bus.wrap === 1'b1) wrap_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_up();
    bus.btn_up = 1'b1; cyc(1);
    bus.btn_up = 1'b0; cyc(1);
  endtask

  task automatic press_dn();
    bus.btn_down = 1'b1; cyc(1);
    bus.btn_down = 1'b0; cyc(1);
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1; cyc(1);
    bus.tick = 1'b0; cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.tick = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.clear = 1'b0;
    cyc(3);
    cmp_en = 1;
    rst = 1'b0;
    cyc(10);
    check("reset_num", 32'(bus.num), 32'h00020);
    check("reset_wrap", 32'(bus.wrap), 32'h0);
    check("model_reset", 32'(to_num(val)), 32'h00020);

    // Twelve single presses; carry into digit 1 on the tenth.
    for (int i = 1; i <= 12; i++) begin
      press_up();
      if (i == 10) check("carry_0010", 32'(bus.num), 32'h00060);
    end
    check("count_0012", 32'(bus.num), 32'h00064);
    check("model_0012", 32'(val), 32'd12);

    // Fresh reset, then roll under and roll over.
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(2);
    wrap_seen = 0;
    press_dn();
    check("under_9999", 32'(bus.num), 32'h94A72);
    cyc(1);
    check("under_wrap_pulses", 32'(wrap_seen), 32'd1);
    wrap_seen = 0;
    press_up();
    check("over_0000", 32'(bus.num), 32'h00020);
    cyc(1);
    check("over_wrap_pulses", 32'(wrap_seen), 32'd1);

    // Hold for 7 ticks: steps at press, tick 3, tick 5, tick 7.
    bus.btn_up = 1'b1; cyc(1);
    check("hold_first_step", 32'(bus.num), 32'h00022);
    for (int i = 1; i <= 7; i++) tick_pulse();
    check("hold_0004", 32'(bus.num), 32'h00028);
    bus.btn_up = 1'b0; cyc(4);
    check("release_0004", 32'(bus.num), 32'h00028);

    // Opposite button before the delay expires locks out stepping.
    bus.btn_up = 1'b1; cyc(1);
    tick_pulse();
    bus.btn_down = 1'b1; cyc(1);
    for (int i = 0; i < 4; i++) tick_pulse();
    check("lock_0005", 32'(bus.num), 32'h0002A);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0; cyc(2);
    press_dn();
    check("after_lock_dec", 32'(bus.num), 32'h00028);

    // Reach 0057 inside REPEAT, then clear with the button still held.
    for (int i = 0; i < 51; i++) press_up();
    bus.btn_up = 1'b1; cyc(1);
    for (int i = 0; i < 3; i++) tick_pulse();
    check("repeat_0057", 32'(bus.num), 32'h0016E);
    bus.clear = 1'b1; cyc(1);
    check("clear_num", 32'(bus.num), 32'h00020);
    check("clear_wrap", 32'(bus.wrap), 32'h0);
    for (int i = 0; i < 4; i++) tick_pulse();
    check("clear_held", 32'(bus.num), 32'h00020);
    bus.clear = 1'b0; cyc(1);
    for (int i = 0; i < 3; i++) tick_pulse();
    check("post_clear_locked", 32'(bus.num), 32'h00020);
    bus.btn_up = 1'b0; cyc(2);
    press_up();
    check("repress_0001", 32'(bus.num), 32'h00022);
    check("model_0001", 32'(val), 32'd1);

    cyc(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
